// File: rtl/axis_frame_receiver_if.sv
// ----------------------------------------------------------------------------
// axis_frame_receiver_if
// AXI-Stream bundle used by axis_frame_receiver.
//   tdata  : stream word (DATA_WIDTH bits)
//   tvalid : source has a word
//   tready : sink accepts the word
//   tlast  : final word of a packet
// master modport drives data/valid/last, slave modport drives ready.
// ----------------------------------------------------------------------------
interface axis_frame_receiver_if #(
   parameter int DATA_WIDTH = 20
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_receiver.sv
// ----------------------------------------------------------------------------
// axis_frame_receiver
// AXI-Stream sink for header-framed result packets. Six header words
// (magic, opcode, bank range, start address, words per bank, reserved or
// checksum) are stripped and decoded, then the payload is scattered into BRAM
// banks bank-major / address-minor. Framing errors are collected in sticky
// flags.
//
// Ports
//   aclk, aresetn       clock, asynchronous active-low reset
//   s_axis (slave)      stream input: tdata/tvalid/tready/tlast
//   sink_hold           1 = deassert tready
//   bram_wr_data/addr   write data/address broadcast to all banks
//   bram_wr_en          one-hot bank write enable
//   hdr_opcode, hdr_bram_start, hdr_bram_end, hdr_addr_start, hdr_addr_count
//                       latched header fields
//   hdr_valid           pulse: header accepted
//   notify_valid        pulse: header-only packet
//   frame_done          pulse: payload completed with correct tlast
//   err_flags           sticky [0] magic/checksum [1] short hdr
//                              [2] short payload [3] long payload
//   err_clear           synchronous clear of err_flags
//
// Configuration macro: HDR_CHECKSUM_EN -- when defined, header word 5 must be
// the XOR of words 0..4; otherwise word 5 is ignored.
// ----------------------------------------------------------------------------
module axis_frame_receiver #(
   parameter int          DATA_WIDTH = 20,
   parameter int          BRAM_COUNT = 8,
   parameter int          ADDR_WIDTH = 9,
   parameter logic [15:0] HDR_MAGIC  = 16'hC0DE
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axis_frame_receiver_if.slave  s_axis,
   input  logic                  sink_hold,
   output logic [DATA_WIDTH-1:0] bram_wr_data,
   output logic [ADDR_WIDTH-1:0] bram_wr_addr,
   output logic [BRAM_COUNT-1:0] bram_wr_en,
   output logic [15:0]           hdr_opcode,
   output logic [2:0]            hdr_bram_start,
   output logic [2:0]            hdr_bram_end,
   output logic [15:0]           hdr_addr_start,
   output logic [15:0]           hdr_addr_count,
   output logic                  hdr_valid,
   output logic                  notify_valid,
   output logic                  frame_done,
   output logic [3:0]            err_flags,
   input  logic                  err_clear
);

   typedef enum logic [1:0] {HDR, PAY, DRAIN} state_t;

   state_t      state;
   logic [2:0]  hdr_cnt;
   logic [2:0]  bank;
   logic [15:0] addr;

   logic        beat;
   logic [15:0] word;
   logic [15:0] addr_end;
   logic        last_in_bank;
   logic        last_bank;
   logic        bank_ok;
   logic        hdr_ok;

   // Ready never looks at tvalid; only the downstream stall gates it.
   assign s_axis.tready = ~sink_hold;
   assign beat          = s_axis.tvalid & ~sink_hold;
   assign word          = s_axis.tdata[15:0];

   // 16-bit address arithmetic; the end marker wraps modulo 2^16 like addr.
   assign addr_end     = hdr_addr_start + hdr_addr_count;
   assign last_in_bank = ((addr + 16'd1) == addr_end);
   assign last_bank    = (bank == hdr_bram_end);
   assign bank_ok      = (int'(bank) < BRAM_COUNT);

`ifdef HDR_CHECKSUM_EN
   logic [15:0] hdr_xor;
   assign hdr_ok = (word == hdr_xor);
`else
   assign hdr_ok = 1'b1;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state          <= HDR;
         hdr_cnt        <= 3'd0;
         bank           <= 3'd0;
         addr           <= 16'd0;
         bram_wr_data   <= '0;
         bram_wr_addr   <= '0;
         bram_wr_en     <= '0;
         hdr_opcode     <= 16'd0;
         hdr_bram_start <= 3'd0;
         hdr_bram_end   <= 3'd0;
         hdr_addr_start <= 16'd0;
         hdr_addr_count <= 16'd0;
         hdr_valid      <= 1'b0;
         notify_valid   <= 1'b0;
         frame_done     <= 1'b0;
         err_flags      <= 4'd0;
`ifdef HDR_CHECKSUM_EN
         hdr_xor        <= 16'd0;
`endif
      end else begin
         hdr_valid    <= 1'b0;
         notify_valid <= 1'b0;
         frame_done   <= 1'b0;
         bram_wr_en   <= '0;
         // Clear first: a bit set later in this block wins, so an error in
         // the clearing cycle survives.
         if (err_clear) err_flags <= 4'd0;

         if (beat) begin
            case (state)
               HDR: begin
                  if (hdr_cnt == 3'd0 && word != HDR_MAGIC) begin
                     err_flags[0] <= 1'b1;
                     state        <= s_axis.tlast ? HDR : DRAIN;
                  end else if (hdr_cnt != 3'd5) begin
                     case (hdr_cnt)
                        3'd1: hdr_opcode <= word;
                        3'd2: begin
                           hdr_bram_start <= word[2:0];
                           hdr_bram_end   <= word[10:8];
                        end
                        3'd3: hdr_addr_start <= word;
                        3'd4: hdr_addr_count <= word;
                        default: ;
                     endcase
`ifdef HDR_CHECKSUM_EN
                     hdr_xor <= (hdr_cnt == 3'd0) ? word : (hdr_xor ^ word);
`endif
                     if (s_axis.tlast) begin
                        err_flags[1] <= 1'b1;
                        hdr_cnt      <= 3'd0;
                     end else begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                     end
                  end else begin
                     hdr_cnt <= 3'd0;
                     if (!hdr_ok) begin
                        err_flags[0] <= 1'b1;
                        state        <= s_axis.tlast ? HDR : DRAIN;
                     end else begin
                        hdr_valid <= 1'b1;
                        if (s_axis.tlast) begin
                           notify_valid <= 1'b1;
                        end else if (hdr_addr_count == 16'd0 ||
                                     hdr_bram_end < hdr_bram_start) begin
                           // Payload present but the header describes none.
                           err_flags[3] <= 1'b1;
                           state        <= DRAIN;
                        end else begin
                           bank  <= hdr_bram_start;
                           addr  <= hdr_addr_start;
                           state <= PAY;
                        end
                     end
                  end
               end

               PAY: begin
                  bram_wr_data <= s_axis.tdata;
                  bram_wr_addr <= addr[ADDR_WIDTH-1:0];
                  // Banks beyond BRAM_COUNT are counted but never written.
                  bram_wr_en   <= bank_ok ? (BRAM_COUNT'(1) << bank) : '0;
                  if (last_in_bank && last_bank) begin
                     if (s_axis.tlast) begin
                        frame_done <= 1'b1;
                        state      <= HDR;
                     end else begin
                        err_flags[3] <= 1'b1;
                        state        <= DRAIN;
                     end
                  end else if (s_axis.tlast) begin
                     err_flags[2] <= 1'b1;
                     state        <= HDR;
                  end else if (last_in_bank) begin
                     bank <= bank + 3'd1;
                     addr <= hdr_addr_start;
                  end else begin
                     addr <= addr + 16'd1;
                  end
               end

               DRAIN: begin
                  if (s_axis.tlast) state <= HDR;
               end

               default: state <= HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_receiver.sv
module tb_axis_frame_receiver;
   localparam int DW = 20;
   localparam int BC = 8;
   localparam int AW = 9;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          sink_hold;
   logic          err_clear;
   logic [DW-1:0] bram_wr_data;
   logic [AW-1:0] bram_wr_addr;
   logic [BC-1:0] bram_wr_en;
   logic [15:0]   hdr_opcode;
   logic [2:0]    hdr_bram_start;
   logic [2:0]    hdr_bram_end;
   logic [15:0]   hdr_addr_start;
   logic [15:0]   hdr_addr_count;
   logic          hdr_valid;
   logic          notify_valid;
   logic          frame_done;
   logic [3:0]    err_flags;

   axis_frame_receiver_if #(.DATA_WIDTH(DW)) s_if ();

   axis_frame_receiver #(
      .DATA_WIDTH(DW), .BRAM_COUNT(BC), .ADDR_WIDTH(AW), .HDR_MAGIC(16'hC0DE)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axis(s_if), .sink_hold(sink_hold),
      .bram_wr_data(bram_wr_data), .bram_wr_addr(bram_wr_addr),
      .bram_wr_en(bram_wr_en), .hdr_opcode(hdr_opcode),
      .hdr_bram_start(hdr_bram_start), .hdr_bram_end(hdr_bram_end),
      .hdr_addr_start(hdr_addr_start), .hdr_addr_count(hdr_addr_count),
      .hdr_valid(hdr_valid), .notify_valid(notify_valid),
      .frame_done(frame_done), .err_flags(err_flags), .err_clear(err_clear)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [2:0]    bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   int            checks = 0;
   int            failures = 0;
   wr_t           exp_q[$];
   logic [DW-1:0] pkt[$];
   wr_t           mon_e;
   int            wr_seen = 0, fd_seen = 0, hv_seen = 0, nv_seen = 0;
   bit            gaps = 1'b0;
   bit            hold_en = 1'b0;
   int            w0, fd0, hv0, nv0;

   // Scoreboard monitor: every write is compared against the model queue.
   always @(negedge aclk) begin
      if (frame_done)   fd_seen++;
      if (hdr_valid)    hv_seen++;
      if (notify_valid) nv_seen++;
      if (bram_wr_en != '0) begin
         wr_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write en=%b addr=%h data=%h required=no write",
                     bram_wr_en, bram_wr_addr, bram_wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (bram_wr_en !== (BC'(1) << mon_e.bank) || bram_wr_addr !== mon_e.addr ||
                bram_wr_data !== mon_e.data) begin
               failures++;
               $display("FAIL write en=%b addr=%h data=%h required en=%b addr=%h data=%h",
                        bram_wr_en, bram_wr_addr, bram_wr_data,
                        BC'(1) << mon_e.bank, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   always @(negedge aclk) begin
      if (hold_en) sink_hold = ($urandom_range(0, 2) == 0);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l);
      bit ok = 1'b0;
      if (gaps) idle($urandom_range(0, 2));
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         @(posedge aclk);
         if (s_if.tready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout tready=%b required=1", s_if.tready);
      end
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic send_pkt();
      for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], i == pkt.size() - 1);
      pkt.delete();
   endtask

   // Builds a header (word 5 = XOR of words 0..4) plus npay payload words and
   // pushes the first nexp expected writes from a bank-major model.
   task automatic build_frame(input logic [15:0] op, input logic [2:0] bs,
                              input logic [2:0] be, input logic [15:0] as,
                              input logic [15:0] cnt, input int npay, input int nexp);
      logic [15:0] h[6];
      int idx = 0;
      wr_t tmp;
      h[0] = 16'hC0DE; h[1] = op; h[2] = {5'd0, be, 5'd0, bs}; h[3] = as; h[4] = cnt;
      h[5] = h[0] ^ h[1] ^ h[2] ^ h[3] ^ h[4];
      for (int i = 0; i < 6; i++) pkt.push_back({4'($urandom), h[i]});
      for (int b = int'(bs); b <= int'(be); b++) begin
         for (int i = 0; i < int'(cnt); i++) begin
            if (idx < npay) begin
               tmp.bank = 3'(b);
               tmp.addr = AW'(as + 16'(i));
               tmp.data = DW'($urandom);
               pkt.push_back(tmp.data);
               if (idx < nexp) exp_q.push_back(tmp);
            end
            idx++;
         end
      end
      while (pkt.size() < 6 + npay) pkt.push_back(DW'($urandom));
   endtask

   task automatic snap();
      w0 = wr_seen; fd0 = fd_seen; hv0 = hv_seen; nv0 = nv_seen;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      idle(1);
      err_clear = 1'b0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      idle(2);
      checks++; if (bram_wr_en !== '0) begin failures++; $display("FAIL rst_wr_en got=%b required=0", bram_wr_en); end
      checks++; if ({hdr_valid, notify_valid, frame_done} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%b required=000", {hdr_valid, notify_valid, frame_done}); end
      checks++; if (err_flags !== 4'd0) begin failures++; $display("FAIL rst_err got=%b required=0000", err_flags); end
      checks++; if (hdr_opcode !== 16'd0 || hdr_addr_count !== 16'd0) begin failures++; $display("FAIL rst_hdr got=%h/%h required=0/0", hdr_opcode, hdr_addr_count); end
      checks++; if (s_if.tready !== 1'b1) begin failures++; $display("FAIL rst_tready got=%b required=1", s_if.tready); end
      @(negedge aclk);
      aresetn = 1'b1;
      idle(1);
   endtask

   task automatic test_full_frame();
      snap();
      build_frame(16'h0007, 3'd0, 3'd1, 16'h0010, 16'h0004, 8, 8);
      send_pkt();
      checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL full_frame_done_timing got=%b required=1", frame_done); end
      idle(2);
      checks++; if (wr_seen - w0 != 8 || exp_q.size() != 0) begin failures++; $display("FAIL full_writes got=%0d left=%0d required=8/0", wr_seen - w0, exp_q.size()); end
      checks++; if (fd_seen - fd0 != 1 || hv_seen - hv0 != 1) begin failures++; $display("FAIL full_pulses fd=%0d hv=%0d required=1/1", fd_seen - fd0, hv_seen - hv0); end
      checks++; if (hdr_opcode !== 16'h0007 || hdr_bram_end !== 3'd1 || hdr_addr_start !== 16'h0010 || hdr_addr_count !== 16'h0004)
         begin failures++; $display("FAIL full_hdr got=%h %0d %h %h required=0007 1 0010 0004", hdr_opcode, hdr_bram_end, hdr_addr_start, hdr_addr_count); end
      checks++; if (err_flags !== 4'd0) begin failures++; $display("FAIL full_err got=%b required=0000", err_flags); end
   endtask

   task automatic test_notify();
      snap();
      build_frame(16'h0042, 3'd0, 3'd0, 16'h0000, 16'h0001, 0, 0);
      send_pkt();
      checks++; if (hdr_valid !== 1'b1 || notify_valid !== 1'b1) begin failures++; $display("FAIL notify_pulse got=%b%b required=11", hdr_valid, notify_valid); end
      idle(2);
      checks++; if (wr_seen != w0 || nv_seen - nv0 != 1 || hv_seen - hv0 != 1) begin failures++; $display("FAIL notify_counts wr=%0d nv=%0d hv=%0d required=0/1/1", wr_seen - w0, nv_seen - nv0, hv_seen - hv0); end
      snap();
      build_frame(16'h0003, 3'd2, 3'd3, 16'h0100, 16'h0003, 6, 6);
      send_pkt();
      idle(2);
      checks++; if (fd_seen - fd0 != 1 || exp_q.size() != 0 || wr_seen - w0 != 6) begin failures++; $display("FAIL notify_next fd=%0d wr=%0d left=%0d required=1/6/0", fd_seen - fd0, wr_seen - w0, exp_q.size()); end
   endtask

   task automatic test_short_payload();
      snap();
      build_frame(16'h0005, 3'd2, 3'd2, 16'h0020, 16'h0004, 2, 2);
      send_pkt();
      idle(2);
      checks++; if (err_flags !== 4'b0100) begin failures++; $display("FAIL short_err got=%b required=0100", err_flags); end
      checks++; if (wr_seen - w0 != 2 || exp_q.size() != 0 || fd_seen != fd0) begin failures++; $display("FAIL short_writes got=%0d fd=%0d required=2/0", wr_seen - w0, fd_seen - fd0); end
      pulse_clear();
      checks++; if (err_flags !== 4'd0) begin failures++; $display("FAIL short_clear got=%b required=0000", err_flags); end
   endtask

   task automatic test_long_payload();
      snap();
      build_frame(16'h0005, 3'd2, 3'd2, 16'h0020, 16'h0004, 5, 4);
      send_pkt();
      idle(2);
      checks++; if (err_flags !== 4'b1000) begin failures++; $display("FAIL long_err got=%b required=1000", err_flags); end
      checks++; if (wr_seen - w0 != 4 || exp_q.size() != 0 || fd_seen != fd0) begin failures++; $display("FAIL long_writes got=%0d fd=%0d required=4/0", wr_seen - w0, fd_seen - fd0); end
      snap();
      build_frame(16'h0006, 3'd4, 3'd4, 16'h0030, 16'h0002, 2, 2);
      send_pkt();
      idle(2);
      checks++; if (fd_seen - fd0 != 1 || exp_q.size() != 0) begin failures++; $display("FAIL long_next fd=%0d left=%0d required=1/0", fd_seen - fd0, exp_q.size()); end
      pulse_clear();
   endtask

   task automatic test_bad_magic();
      snap();
      pkt.push_back({4'h0, 16'hBEEF});
      for (int i = 0; i < 9; i++) pkt.push_back(DW'($urandom));
      send_pkt();
      idle(2);
      checks++; if (err_flags !== 4'b0001) begin failures++; $display("FAIL magic_err got=%b required=0001", err_flags); end
      checks++; if (wr_seen != w0 || hv_seen != hv0) begin failures++; $display("FAIL magic_writes wr=%0d hv=%0d required=0/0", wr_seen - w0, hv_seen - hv0); end
      snap();
      build_frame(16'h0009, 3'd5, 3'd6, 16'h0040, 16'h0003, 6, 6);
      send_pkt();
      idle(2);
      checks++; if (fd_seen - fd0 != 1 || exp_q.size() != 0 || err_flags !== 4'b0001) begin failures++; $display("FAIL magic_next fd=%0d left=%0d err=%b required=1/0/0001", fd_seen - fd0, exp_q.size(), err_flags); end
      pulse_clear();
      checks++; if (err_flags !== 4'd0) begin failures++; $display("FAIL magic_clear got=%b required=0000", err_flags); end
      // Truncated header.
      pkt.push_back({4'h0, 16'hC0DE}); pkt.push_back(20'h00001); pkt.push_back(20'h00002);
      send_pkt();
      checks++; if (err_flags !== 4'b0010) begin failures++; $display("FAIL short_hdr_err got=%b required=0010", err_flags); end
      // Clear and a new magic error in the same cycle: only the new bit stays.
      err_clear = 1'b1;
      send_beat({4'h0, 16'hBEEF}, 1'b1);
      err_clear = 1'b0;
      checks++; if (err_flags !== 4'b0001) begin failures++; $display("FAIL clear_vs_new got=%b required=0001", err_flags); end
      pulse_clear();
   endtask

   task automatic test_stall();
      sink_hold = 1'b1;
      #1;
      checks++; if (s_if.tready !== 1'b0) begin failures++; $display("FAIL hold_tready got=%b required=0", s_if.tready); end
      sink_hold = 1'b0;
      snap();
      gaps = 1'b1;
      hold_en = 1'b1;
      build_frame(16'h000A, 3'd0, 3'd1, 16'h01FE, 16'h0005, 10, 10);
      send_pkt();
      hold_en = 1'b0;
      gaps = 1'b0;
      sink_hold = 1'b0;
      idle(3);
      checks++; if (fd_seen - fd0 != 1 || exp_q.size() != 0 || wr_seen - w0 != 10 || err_flags !== 4'd0)
         begin failures++; $display("FAIL stall_frame fd=%0d wr=%0d left=%0d err=%b required=1/10/0/0000", fd_seen - fd0, wr_seen - w0, exp_q.size(), err_flags); end
   endtask

   task automatic test_async_reset();
      build_frame(16'h0011, 3'd0, 3'd0, 16'h0040, 16'h0008, 8, 8);
      for (int i = 0; i < 9; i++) send_beat(pkt[i], 1'b0);
      pkt.delete();
      #1;
      aresetn = 1'b0;
      #1;
      checks++; if (bram_wr_en !== '0 || bram_wr_addr !== '0 || bram_wr_data !== '0) begin failures++; $display("FAIL areset_wr en=%b addr=%h data=%h required=0", bram_wr_en, bram_wr_addr, bram_wr_data); end
      checks++; if (hdr_opcode !== 16'd0 || hdr_addr_start !== 16'd0) begin failures++; $display("FAIL areset_hdr got=%h/%h required=0/0", hdr_opcode, hdr_addr_start); end
      exp_q.delete();
      idle(1);
      aresetn = 1'b1;
      idle(1);
      snap();
      build_frame(16'h0012, 3'd1, 3'd1, 16'h0000, 16'h0002, 2, 2);
      send_pkt();
      idle(2);
      checks++; if (fd_seen - fd0 != 1 || exp_q.size() != 0 || wr_seen - w0 != 2) begin failures++; $display("FAIL areset_next fd=%0d wr=%0d left=%0d required=1/2/0", fd_seen - fd0, wr_seen - w0, exp_q.size()); end
   endtask

   task automatic test_word5();
      snap();
`ifdef HDR_CHECKSUM_EN
      build_frame(16'h0013, 3'd0, 3'd0, 16'h0008, 16'h0002, 2, 0);
      pkt[5] = pkt[5] ^ 20'h00001;
      send_pkt();
      idle(2);
      checks++; if (err_flags !== 4'b0001 || wr_seen != w0 || hv_seen != hv0) begin failures++; $display("FAIL checksum_bad err=%b wr=%0d hv=%0d required=0001/0/0", err_flags, wr_seen - w0, hv_seen - hv0); end
`else
      build_frame(16'h0013, 3'd0, 3'd0, 16'h0008, 16'h0002, 2, 2);
      pkt[5] = pkt[5] ^ 20'h00001;
      send_pkt();
      idle(2);
      checks++; if (err_flags !== 4'd0 || fd_seen - fd0 != 1 || exp_q.size() != 0) begin failures++; $display("FAIL word5_ignored err=%b fd=%0d left=%0d required=0000/1/0", err_flags, fd_seen - fd0, exp_q.size()); end
`endif
      pulse_clear();
   endtask

   initial begin
      s_if.tdata  = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      sink_hold   = 1'b0;
      err_clear   = 1'b0;
      aresetn     = 1'b0;
      test_reset();
      test_full_frame();
      test_notify();
      test_short_payload();
      test_long_payload();
      test_bad_magic();
      test_stall();
      test_async_reset();
      test_word5();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
